tx_stream_arbiter: RTL
======================

# tx_stream_arbiter

Shares the single USB-CDC transmit byte stream between two requesters: port A (CPU core UART TX) and port B (debug/monitor source). Grants are line-locked: once a requester owns the stream, it keeps it until it sends the line terminator or goes idle past a timeout, so lines from the two sources never interleave. It sits between the requesters and the `usbcdc` `tx_*` interface, and adds one registered output stage.

## Interface
- `IDLE_TIMEOUT`, default 4800: consecutive cycles of owner `*_valid` low before the grant is revoked. The legal range is ≥1 and fits a 16-bit counter.
- `LOCK_CHAR`, default 8'h0A: byte value whose acceptance releases the grant.
- `clk`  in  1  Single clock for the whole block.
- `rst_n`  in  1  Reset, synchronous and active-low.
- `a_data`  in  8  Requester A byte.
- `a_valid`  in  1  Requester A byte is available.
- `a_ready`  out  1  Requester A byte is accepted this cycle.
- `b_data`, `b_valid`, `b_ready`: same as the A port, for requester B.
- `tx_data`  out  8  Byte to `usbcdc`.
- `tx_valid`  out  1  Output byte is pending.
- `tx_ready`  in  1  `usbcdc` accepts the output byte.
- `owner`  out  1  Current grant holder: 0 = A, 1 = B. Valid only while `locked` is high.
- `locked`  out  1  A grant is active.

## Operation
- Handshakes are valid/ready. A transfer occurs on a cycle where valid and ready are both high. Once valid is asserted, data must stay stable until the transfer.
- The FSM has three states: IDLE, GRANT_A, GRANT_B.
- **IDLE:**
  - No `*_ready` is asserted.
  - If only A is valid, go to GRANT_A. If only B is valid, go to GRANT_B.
  - If both are valid, grant the port that is not `last_owner` (round-robin).
  - If neither is valid, stay in IDLE.
- **GRANT_x:**
  - `x_ready = !tx_valid || tx_ready`. The other port's ready stays 0.
  - An accepted byte loads the output register (`tx_data`, `tx_valid` = 1).
- **Release from GRANT_x to IDLE** happens on either of:
  - acceptance of a byte equal to `LOCK_CHAR` (that byte is still forwarded);
  - the timeout counter reaching `IDLE_TIMEOUT`.
- **On release**, `last_owner` is set to x.
- **Timeout counter:**
  - clears on entry to GRANT_x and on any cycle with `x_valid` = 1;
  - increments on each cycle with `x_valid` = 0;
  - saturates and does not wrap.
  - A requester stalled by downstream back-pressure (valid high, ready low) never times out.
- **Output register:**
  - clears `tx_valid` on `tx_ready` when no new byte is loaded;
  - when a drain and a load happen in the same cycle, the load wins and `tx_valid` stays 1;
  - drains independently of the FSM, so a pending byte survives release to IDLE.
- `locked` = (state != IDLE). `owner` = 1 in GRANT_B, 0 otherwise.

## Timing
- **Reset values:**
  - `tx_valid` = 0, `tx_data` = 8'h00;
  - `a_ready` = `b_ready` = 0, `locked` = 0, `owner` = 0;
  - state = IDLE, `last_owner` = B (so A wins the first contention), counter = 0.
- **Reset mid-operation:** the pending output byte is discarded and the grant is dropped. The next cycle is IDLE.
- **Grant latency:** a request seen in IDLE at cycle N gives ready at N+1, provided the output register is empty or draining.
- **Throughput:** 1 byte per cycle while granted and `tx_ready` is held high.
- **Input-to-output latency:** a byte accepted at cycle N appears on `tx_data`/`tx_valid` at N+1.
- **Release latency:**
  - `LOCK_CHAR` accepted at N → IDLE at N+1 → next grant takes effect at N+2 (ready earliest N+2).
  - The timeout fires on the cycle the counter equals `IDLE_TIMEOUT` → IDLE on the following cycle.
- **Simultaneous events:** `LOCK_CHAR` acceptance and timeout in the same cycle resolve as a single release.
- `*_ready` is combinational from the state, `tx_valid` and `tx_ready`. There is no path from `*_valid` to `*_ready`.

## Structure
- Shared package/header `stream_defs`:
  - state encoding (IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2);
  - owner constants (OWNER_A = 1'b0, OWNER_B = 1'b1).
- Sub-module `stream_reg`: one-entry valid/ready pipeline register, 8-bit data, synchronous active-low reset. It is reusable for the PS/2 and VGA write paths.
- The FSM, round-robin pointer and timeout counter stay in `tx_stream_arbiter`.

## Test plan
- **Contention after reset:** A sends "hi\n" and B sends "ok\n", both valid at cycle 0 → `tx` carries 68 69 0A 6F 6B 0A in that order. `owner` is 0 during the A bytes and 1 during the B bytes.
- **Back-pressure:** `tx_ready` alternates 1/0 during "abc\n" from A → no byte is lost or duplicated, `tx_data` is stable while `tx_valid && !tx_ready`, and `b_ready` stays 0 throughout.
- **Timeout:** with `IDLE_TIMEOUT` = 8, A sends 0x41 then drops valid while B is valid → after 8 idle cycles `locked` falls, B is granted 2 cycles later, and the output is 0x41 then B's bytes.
- **No timeout under stall:** A is valid with `tx_ready` = 0 for 20 cycles and `IDLE_TIMEOUT` = 8 → the grant stays with A. The byte transfers once `tx_ready` rises.
- **Reset mid-line:** `rst_n` = 0 for 1 cycle after A's first byte, while that byte is pending on the output → the next cycle shows `tx_valid` = 0, `locked` = 0 and `owner` = 0. The next contention is won by A.
- **Round-robin fairness:** A and B both continuously send single-byte lines of 0x0A → grants alternate A, B, A, B, with one 0x0A every 2 cycles on the output.

Source files
------------

// File: rtl/stream_defs_pkg.sv
// -----------------------------------------------------------------------------
// stream_defs
// Shared definitions for the byte-stream blocks: arbiter state encoding,
// owner constants and the timeout counter width.
// -----------------------------------------------------------------------------
package stream_defs;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_A = 2'd1,
      ST_GRANT_B = 2'd2
   } arb_state_e;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   localparam int CNT_W = 16;

endpackage : stream_defs

// File: rtl/stream_reg.sv
// -----------------------------------------------------------------------------
// stream_reg
// One-entry valid/ready pipeline register (8-bit data by default).
// A new byte may be loaded while the held byte drains in the same cycle, so
// the register sustains one transfer per cycle.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   in_data_i    in   upstream byte
//   in_valid_i   in   upstream byte available
//   in_ready_o   out  register can take a byte this cycle
//   out_data_o   out  held byte
//   out_valid_o  out  held byte pending
//   out_ready_i  in   downstream takes the held byte
// -----------------------------------------------------------------------------
module stream_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [W-1:0] out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;
   logic         load;

   // Ready depends only on our own state and the downstream ready, never on
   // in_valid_i, which keeps the upstream handshake free of combinational loops.
   assign in_ready_o = !valid_q || out_ready_i;
   assign load       = in_valid_i && in_ready_o;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         // A load in the same cycle as a drain wins: the slot stays full.
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: reset is sampled on the clock edge (synchronous), and the data
   // register is cleared too so tx_data reads a defined 8'h00 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments for every flop so all state updates
         // see the same pre-edge values.
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule : stream_reg

// File: rtl/tx_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tx_stream_arbiter
// Shares the single USB-CDC transmit byte stream between requester A (CPU
// UART TX) and requester B (debug/monitor). Grants are line-locked: the owner
// keeps the stream until a LOCK_CHAR byte is accepted or its valid stays low
// for IDLE_TIMEOUT cycles. Contention in IDLE is resolved round-robin.
// One registered output stage (stream_reg) drives the tx_* interface.
//
// Ports:
//   clk                    in   clock
//   rst_n                  in   synchronous active-low reset
//   a_data/a_valid/a_ready      requester A byte stream
//   b_data/b_valid/b_ready      requester B byte stream
//   tx_data/tx_valid/tx_ready   stream towards usbcdc
//   owner                  out  grant holder (0 = A, 1 = B), meaningful while locked
//   locked                 out  a grant is active
// -----------------------------------------------------------------------------
module tx_stream_arbiter
   import stream_defs::*;
#(
   parameter int         IDLE_TIMEOUT = 4800,
   parameter logic [7:0] LOCK_CHAR    = 8'h0A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a_data,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [7:0] b_data,
   input  logic       b_valid,
   output logic       b_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       owner,
   output logic       locked
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IDLE_TIMEOUT);

   arb_state_e       state_q, state_d;
   logic             last_owner_q, last_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       grant_a, grant_b;
   logic       reg_ready;
   logic       in_valid;
   logic [7:0] in_data;
   logic       accept;
   logic       own_valid;
   logic       timeout;
   logic       lock_hit;

   assign grant_a = (state_q == ST_GRANT_A);
   assign grant_b = (state_q == ST_GRANT_B);

   // Only the owner sees the output register's ready; IDLE grants nobody.
   assign a_ready = grant_a && reg_ready;
   assign b_ready = grant_b && reg_ready;

   assign in_valid  = (grant_a && a_valid) || (grant_b && b_valid);
   assign in_data   = grant_b ? b_data : a_data;
   assign accept    = in_valid && reg_ready;
   assign own_valid = grant_b ? b_valid : a_valid;

   assign timeout  = (cnt_q == TIMEOUT_CNT);
   assign lock_hit = accept && (in_data == LOCK_CHAR);

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // Holding the counter at zero here makes it start clear on entry.
            cnt_d = '0;
            if (a_valid && b_valid) begin
               state_d = (last_owner_q == OWNER_A) ? ST_GRANT_B : ST_GRANT_A;
            end else if (a_valid) begin
               state_d = ST_GRANT_A;
            end else if (b_valid) begin
               state_d = ST_GRANT_B;
            end
         end
         ST_GRANT_A, ST_GRANT_B: begin
            // Only a missing valid counts as idle; a back-pressured owner keeps
            // valid high and therefore never times out.
            if (own_valid) begin
               cnt_d = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Lock char and timeout in the same cycle are one release.
            if (lock_hit || timeout) begin
               state_d      = ST_IDLE;
               last_owner_d = grant_b ? OWNER_B : OWNER_A;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_owner_q <= OWNER_B;   // A wins the first contention
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

   // The output register drains on its own, so a byte accepted with the
   // releasing lock char still leaves after the FSM has returned to IDLE.
   stream_reg #(
      .W (8)
   ) u_out_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (reg_ready),
      .out_data_o  (tx_data),
      .out_valid_o (tx_valid),
      .out_ready_i (tx_ready)
   );

   assign locked = (state_q != ST_IDLE);
   assign owner  = grant_b ? OWNER_B : OWNER_A;

endmodule : tx_stream_arbiter
